// File: rtl/soc_fpga_intf_dma_arb.sv
// Multi-channel DMA request/acknowledge bridge: synchronised fabric requests, round-robin grant to the SoC DMA engine.
// Optional macro DMA_TIMEOUT_EN adds a SoC response timeout with sticky per-channel error flags.
module soc_fpga_intf_dma_arb #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              DMA_CLK,
  input  logic              DMA_RST_N,
  input  logic [NUM_CH-1:0] DMA_REQ,
  input  logic [NUM_CH-1:0] DMA_CH_EN,
  output logic [NUM_CH-1:0] DMA_ACK,
  output logic [NUM_CH-1:0] SOC_DMA_REQ,
  input  logic              SOC_DMA_DONE,
  output logic              DMA_BUSY,
  output logic [NUM_CH-1:0] DMA_ERR,
  input  logic [NUM_CH-1:0] DMA_ERR_CLR
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] eligible;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   scan_idx;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [CH_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_CH-1:0] soc_req_reg, soc_req_next;
  logic [NUM_CH-1:0] ack_reg, ack_next;
  logic              busy_reg, busy_next;
  logic [NUM_CH-1:0] err_set;
  logic [NUM_CH-1:0] grant_oh, ch_oh;
  logic              timeout_hit;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = DMA_REQ;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_reg [SYNC_STAGES];
      always_ff @(posedge DMA_CLK or negedge DMA_RST_N) begin
        if (!DMA_RST_N) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
        end else begin
          sync_reg[0] <= DMA_REQ;
          for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
        end
      end
      assign req_s = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
    assign eligible[gi] = req_s[gi] & DMA_CH_EN[gi];
  end

  // Round-robin scan: first eligible channel at or after the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = CH_W'((int'(ptr_reg) + i) % NUM_CH);
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign grant_oh = NUM_CH'(1) << grant_idx;
  assign ch_oh    = NUM_CH'(1) << ch_reg;

`ifdef DMA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]  cnt_reg;
  logic [NUM_CH-1:0] err_reg;

  always_ff @(posedge DMA_CLK or negedge DMA_RST_N) begin
    if (!DMA_RST_N)            cnt_reg <= '0;
    else if (state_reg == ISSUE) cnt_reg <= cnt_reg + 1'b1;
    else                       cnt_reg <= '0;
  end

  assign timeout_hit = (state_reg == ISSUE) && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // A set on the same edge as a clear wins.
  always_ff @(posedge DMA_CLK or negedge DMA_RST_N) begin
    if (!DMA_RST_N) err_reg <= '0;
    else            err_reg <= (err_reg & ~DMA_ERR_CLR) | err_set;
  end

  assign DMA_ERR = err_reg;
`else
  localparam logic [31:0] TIMEOUT_VEC = TIMEOUT_CYCLES;
  logic unused_cfg;
  assign unused_cfg  = ^{DMA_ERR_CLR, err_set, TIMEOUT_VEC[0]};
  assign timeout_hit = 1'b0;
  assign DMA_ERR     = '0;
`endif

  always_ff @(posedge DMA_CLK or negedge DMA_RST_N) begin
    if (!DMA_RST_N) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = ISSUE;
      ISSUE:   if (SOC_DMA_DONE || timeout_hit) state_next = ACK;
      ACK:     if (!req_s[ch_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    soc_req_next = soc_req_reg;
    ack_next     = ack_reg;
    busy_next    = busy_reg;
    ch_next      = ch_reg;
    ptr_next     = ptr_reg;
    err_set      = '0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          soc_req_next = grant_oh;
          busy_next    = 1'b1;
          ch_next      = grant_idx;
          ptr_next     = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      ISSUE: begin
        // Done sampled on the timeout edge takes priority, so no error is raised.
        if (SOC_DMA_DONE || timeout_hit) begin
          soc_req_next = '0;
          ack_next     = ch_oh;
          if (!SOC_DMA_DONE) err_set = ch_oh;
        end
      end
      ACK: begin
        if (!req_s[ch_reg]) begin
          ack_next  = '0;
          busy_next = 1'b0;
        end
      end
      default: begin
        soc_req_next = '0;
        ack_next     = '0;
        busy_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge DMA_CLK or negedge DMA_RST_N) begin
    if (!DMA_RST_N) begin
      soc_req_reg <= '0;
      ack_reg     <= '0;
      busy_reg    <= 1'b0;
      ch_reg      <= '0;
      ptr_reg     <= '0;
    end else begin
      soc_req_reg <= soc_req_next;
      ack_reg     <= ack_next;
      busy_reg    <= busy_next;
      ch_reg      <= ch_next;
      ptr_reg     <= ptr_next;
    end
  end

  assign SOC_DMA_REQ = soc_req_reg;
  assign DMA_ACK     = ack_reg;
  assign DMA_BUSY    = busy_reg;

endmodule

// File: tb/tb_soc_fpga_intf_dma_arb.sv
// Directed bench for soc_fpga_intf_dma_arb (NUM_CH=4, SYNC_STAGES=2, TIMEOUT_CYCLES=8).
module tb_soc_fpga_intf_dma_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, ch_en, err_clr;
  logic       done;
  logic [3:0] ack, soc_req, err;
  logic       busy;
  int         n_cmp = 0;
  int         n_mis = 0;

  always #5 clk = ~clk;

  soc_fpga_intf_dma_arb #(.NUM_CH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
    .DMA_CLK(clk), .DMA_RST_N(rst_n), .DMA_REQ(req), .DMA_CH_EN(ch_en),
    .DMA_ACK(ack), .SOC_DMA_REQ(soc_req), .SOC_DMA_DONE(done),
    .DMA_BUSY(busy), .DMA_ERR(err), .DMA_ERR_CLR(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; ch_en = 4'hF; err_clr = '0; done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (soc_req != 4'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_ack_low(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ack == 4'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ack !== 4'b0)     begin n_mis++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_cmp++; if (soc_req !== 4'b0) begin n_mis++; $display("FAIL reset_soc_req: got %b want 0000", soc_req); end
    n_cmp++; if (busy !== 1'b0)    begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 4'b0)     begin n_mis++; $display("FAIL reset_err: got %b want 0000", err); end
  endtask

  task automatic test_latency();
    do_reset();
    req = 4'b0100;
    tick(); tick();
    n_cmp++; if (soc_req !== 4'b0) begin n_mis++; $display("FAIL lat_cyc2: got %b want 0000", soc_req); end
    tick();
    n_cmp++; if (soc_req !== 4'b0100) begin n_mis++; $display("FAIL lat_cyc3_req: got %b want 0100", soc_req); end
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL lat_cyc3_busy: got %b want 1", busy); end
    tick(); tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++; if (ack !== 4'b0100) begin n_mis++; $display("FAIL lat_cyc6_ack: got %b want 0100", ack); end
    n_cmp++; if (soc_req !== 4'b0) begin n_mis++; $display("FAIL lat_cyc6_req: got %b want 0000", soc_req); end
    tick();
    req = 4'b0;
    tick(); tick();
    n_cmp++; if (ack !== 4'b0100) begin n_mis++; $display("FAIL lat_cyc9_ack: got %b want 0100", ack); end
    tick();
    n_cmp++; if (ack !== 4'b0) begin n_mis++; $display("FAIL lat_cyc10_ack: got %b want 0000", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL lat_cyc10_busy: got %b want 0", busy); end
    $display("xfer ch2 latency sequence done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    logic       ok;
    int         order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp_oh = 4'b0001 << order[n];
      wait_grant(ok);
      n_cmp++; if (!ok || soc_req !== exp_oh) begin n_mis++; $display("FAIL rr_grant%0d: got %b want %b", n, soc_req, exp_oh); end
      $display("grant %0d: soc_req=%b", n, soc_req);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_cmp++; if (ack !== exp_oh) begin n_mis++; $display("FAIL rr_ack%0d: got %b want %b", n, ack, exp_oh); end
      req = req & ~exp_oh;
      wait_ack_low(ok);
      n_cmp++; if (!ok) begin n_mis++; $display("FAIL rr_ack_low%0d: got %b want 0000", n, ack); end
      req = req | exp_oh;
    end
    req = 4'b0;
    repeat (4) tick();
  endtask

  task automatic test_ch_enable();
    logic ok;
    logic seen1 = 1'b0;
    do_reset();
    ch_en = 4'b1101;
    req   = 4'b0011;
    wait_grant(ok);
    n_cmp++; if (!ok || soc_req !== 4'b0001) begin n_mis++; $display("FAIL en_grant: got %b want 0001", soc_req); end
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      if (soc_req[1]) seen1 = 1'b1;
      tick();
    end
    n_cmp++; if (seen1 !== 1'b0) begin n_mis++; $display("FAIL en_ch1_seen: got %b want 0", seen1); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL en_idle_busy: got %b want 0", busy); end
    $display("xfer ch0 with ch1 disabled done");
    req = 4'b0;
  endtask

  task automatic test_async_reset();
    logic ok;
    do_reset();
    req = 4'b0100;
    wait_grant(ok);
    n_cmp++; if (!ok || soc_req !== 4'b0100) begin n_mis++; $display("FAIL ar_grant: got %b want 0100", soc_req); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (soc_req !== 4'b0) begin n_mis++; $display("FAIL ar_soc_req: got %b want 0000", soc_req); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL ar_busy: got %b want 0", busy); end
    req = 4'b0001;
    tick();
    rst_n = 1'b1;
    wait_grant(ok);
    n_cmp++; if (!ok || soc_req !== 4'b0001) begin n_mis++; $display("FAIL ar_regrant: got %b want 0001", soc_req); end
    $display("xfer after async reset: soc_req=%b", soc_req);
    done = 1'b1; tick(); done = 1'b0;
    req = 4'b0;
    repeat (4) tick();
  endtask

`ifdef DMA_TIMEOUT_EN
  task automatic test_timeout();
    logic ok;
    do_reset();
    req = 4'b0010;
    wait_grant(ok);
    n_cmp++; if (!ok || soc_req !== 4'b0010) begin n_mis++; $display("FAIL to_grant: got %b want 0010", soc_req); end
    repeat (7) tick();
    n_cmp++; if (soc_req !== 4'b0010 || err !== 4'b0) begin n_mis++; $display("FAIL to_cyc7: got req %b err %b want 0010 0000", soc_req, err); end
    tick();
    n_cmp++; if (soc_req !== 4'b0) begin n_mis++; $display("FAIL to_req_drop: got %b want 0000", soc_req); end
    n_cmp++; if (err !== 4'b0010) begin n_mis++; $display("FAIL to_err: got %b want 0010", err); end
    n_cmp++; if (ack !== 4'b0010) begin n_mis++; $display("FAIL to_ack: got %b want 0010", ack); end
    err_clr = 4'b0010; tick(); err_clr = 4'b0;
    n_cmp++; if (err !== 4'b0) begin n_mis++; $display("FAIL to_clr: got %b want 0000", err); end
    $display("xfer ch1 timed out and cleared");
    req = 4'b0;
    wait_ack_low(ok);
  endtask

  task automatic test_done_at_timeout();
    logic ok;
    do_reset();
    req = 4'b1000;
    wait_grant(ok);
    repeat (7) tick();
    done = 1'b1; tick(); done = 1'b0;
    n_cmp++; if (ack !== 4'b1000) begin n_mis++; $display("FAIL dt_ack: got %b want 1000", ack); end
    n_cmp++; if (err !== 4'b0) begin n_mis++; $display("FAIL dt_err: got %b want 0000", err); end
    $display("xfer ch3 done on timeout edge");
    req = 4'b0;
    wait_ack_low(ok);
  endtask
`else
  task automatic test_no_timeout();
    logic ok;
    do_reset();
    req = 4'b0010;
    wait_grant(ok);
    repeat (1000) tick();
    n_cmp++; if (soc_req !== 4'b0010) begin n_mis++; $display("FAIL nt_req_held: got %b want 0010", soc_req); end
    n_cmp++; if (err !== 4'b0) begin n_mis++; $display("FAIL nt_err: got %b want 0000", err); end
    done = 1'b1; tick(); done = 1'b0;
    n_cmp++; if (ack !== 4'b0010) begin n_mis++; $display("FAIL nt_ack: got %b want 0010", ack); end
    $display("xfer ch1 waited 1000 cycles without timeout");
    req = 4'b0;
    wait_ack_low(ok);
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_ch_enable();
    test_async_reset();
`ifdef DMA_TIMEOUT_EN
    test_timeout();
    test_done_at_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
